db_conversion_scheduler: RTL
============================

// Module: db_conversion_scheduler
// PURPOSE
//  Shares one signed_binary_12bit_to_dB converter between NUM_CH sensor/audio channels.
//  - Buffers one pending sample per channel.
//  - Grants channels round-robin and drives the converter start/sample handshake.
//  - Tags each dB result with its channel number.
//  - Sits between the per-channel sample front ends and the drum-trigger/level logic.
// PARAMETERS
//  NUM_CH          4    number of requesting channels (2..8)
//  CH_W            2    channel index width, clog2(NUM_CH)
//  TIMEOUT_CYCLES  32   max cycles in WAIT for conv_done before abort
// PORTS
//  clock          in   1            system clock, rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  sample_valid   in   NUM_CH       per-channel 1-cycle strobe; new sample present
//  sample_data    in   NUM_CH*12    packed signed 12-bit samples; ch k at [12k+11:12k]
//  conv_start     out  1            1-cycle start pulse to converter
//  conv_sample    out  12           signed sample presented to converter; held through WAIT
//  conv_db        in   9            converter result (attenuation dB, 0 = full scale)
//  conv_done      in   1            converter 1-cycle done pulse
//  db_valid       out  1            1-cycle strobe; db_value/db_channel valid
//  db_value       out  9            registered dB result
//  db_channel     out  CH_W         channel the result belongs to
//  overrun        out  NUM_CH       sticky; pending sample overwritten before service
//  overrun_clear  in   1            clears all overrun bits
//  timeout_err    out  1            sticky; a conversion hit TIMEOUT_CYCLES (cleared by overrun_clear)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0.
//   - Pending flags 0.
//   - RR pointer = NUM_CH-1, so ch0 wins first.
//   - FSM = IDLE.
//   - A reset mid-conversion discards the conversion silently.
//  Pending buffer:
//   - sample_valid[k] latches sample_data[k] and sets pend[k].
//   - If pend[k] is already set and ch k is not granted this cycle: overwrite the buffer and set overrun[k].
//   - Grant and a new valid on the same channel in the same cycle: the granted (old) value goes to the converter; pend[k] stays set with the new value; no overrun.
//  FSM:
//   - IDLE: if any pend, grant = first pending after the RR pointer (wrapping). Latch its value into conv_sample, clear its pend, update the pointer, go ISSUE. Otherwise stay.
//   - ISSUE: conv_start = 1 for exactly this cycle; go WAIT; clear the timeout counter.
//   - WAIT: on conv_done, capture conv_db and go DONE. Otherwise count; at TIMEOUT_CYCLES set timeout_err and go IDLE with no db_valid.
//   - DONE: db_valid = 1 for one cycle with db_value/db_channel; go IDLE.
//  Handshake rules:
//   - conv_done outside WAIT is ignored.
//   - conv_start is never high two consecutive cycles.
//   - Issue-to-issue minimum is 3 cycles plus converter latency (3..14 cycles).
//  Data path:
//   - db_value and db_channel hold their values between strobes.
//   - conv_db is passed through unmodified (unsigned attenuation, 0..66).
//   - overrun_clear has priority over a same-cycle overrun set.
// CONFIGURATION
//  PEAK_HOLD_EN defined:
//   - Adds output peak_db (NUM_CH*9) and input peak_clear (NUM_CH).
//   - Per channel, on its db_valid: peak = min(peak, db_value), i.e. the loudest value.
//   - peak_clear[k] sets peak[k] to 9'd511; if it coincides with a result, the result is loaded instead.
//   - Reset value is 9'd511.
//  PEAK_HOLD_EN undefined: those ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  Package db_sched_pkg:
//   - FSM state encodings IDLE/ISSUE/WAIT/DONE.
//   - SAMPLE_W = 12, DB_W = 9, PEAK_INIT = 9'd511.
//   - Default NUM_CH/TIMEOUT_CYCLES.
//  Sub-module db_rr_arbiter (combinational grant):
//   - Inputs: pend vector, last-grant pointer.
//   - Outputs: one-hot grant, encoded index, any_req.
//   - The pointer register lives in the top level.
//  The converter is instantiated outside this block.
// TESTING  (bench instantiates the real converter)
//  - ch1 sample 12'sh400 -> conv_sample = 12'h400; db_valid with db_channel = 1, db_value = 9'd6.
//  - ch0 sample 12'sh000 -> db_value = 9'd66. ch2 sample 12'shC00 (-1024) -> db_value = 9'd6.
//  - All 4 channels valid in the same cycle -> results in order ch0, ch1, ch2, ch3; no overrun.
//  - ch3 valid twice before service -> overrun[3] = 1 and the second value is converted; overrun_clear -> 0.
//  - Converter replaced by a stub that never asserts done -> timeout_err = 1 after 32 WAIT cycles; next pending channel is then served.
//  - reset_n low during WAIT -> all outputs 0 immediately; no db_valid after release.
//  - PEAK_HOLD_EN: ch0 gets 12'sh400 then 12'sh100 -> peak_db[ch0] = 6; peak_clear[0] -> 511.

Source files
------------

// File: rtl/db_sched_pkg.sv
// db_sched_pkg: shared types and constants for the dB conversion scheduler.
package db_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int SAMPLE_W = 12;
  localparam int DB_W = 9;
  localparam logic [DB_W-1:0] PEAK_INIT = 9'd511;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TIMEOUT_CYCLES = 32;
endpackage

// File: rtl/db_rr_arbiter.sv
// db_rr_arbiter: combinational round-robin grant, first pending channel after the last grant.
module db_rr_arbiter
  import db_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_pend,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);
  // Scan farthest-first so the nearest pending channel after the pointer wins.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_CH; i >= 1; i--)
      if (i_pend[(int'(i_ptr) + i) % NUM_CH]) o_idx = CH_W'((int'(i_ptr) + i) % NUM_CH);
  end
  assign o_any = |i_pend;
  assign o_grant = o_any ? NUM_CH'(1) << o_idx : '0;
endmodule

// File: rtl/db_conversion_scheduler.sv
// db_conversion_scheduler: shares one 12-bit-to-dB converter between NUM_CH channels, round-robin.
// Define PEAK_HOLD_EN to add per-channel peak (minimum attenuation) hold with peak_db/peak_clear.
module db_conversion_scheduler
  import db_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W = $clog2(NUM_CH),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic                       conv_start,
  output logic [SAMPLE_W-1:0]        conv_sample,
  input  logic [DB_W-1:0]            conv_db,
  input  logic                       conv_done,
  output logic                       db_valid,
  output logic [DB_W-1:0]            db_value,
  output logic [CH_W-1:0]            db_channel,
  output logic [NUM_CH-1:0]          overrun,
  input  logic                       overrun_clear,
`ifdef PEAK_HOLD_EN
  output logic [NUM_CH*DB_W-1:0]     peak_db,
  input  logic [NUM_CH-1:0]          peak_clear,
`endif
  output logic                       timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_next;
  logic [NUM_CH-1:0] r_pend, w_grant, w_take;
  logic [SAMPLE_W-1:0] r_buf [NUM_CH];
  logic [CH_W-1:0] r_ptr, r_ch, w_idx;
  logic [CNT_W-1:0] r_cnt;
  logic w_any, w_timeout;

  db_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .i_pend(r_pend), .i_ptr(r_ptr), .o_grant(w_grant), .o_idx(w_idx), .o_any(w_any)
  );

  assign w_take = (r_state == IDLE) ? w_grant : '0;
  assign w_timeout = (r_state == WAIT) && !conv_done && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    conv_start = (r_state == ISSUE);
    db_valid = (r_state == DONE);
    case (r_state)
      IDLE:    w_next = w_any ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = conv_done ? DONE : (w_timeout ? IDLE : WAIT);
      default: w_next = IDLE;
    endcase
  end

  // A channel being granted this cycle may take a fresh sample without it counting as overrun.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_pend <= '0;
      overrun <= '0;
      for (int k = 0; k < NUM_CH; k++) r_buf[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (sample_valid[k]) r_buf[k] <= sample_data[k*SAMPLE_W +: SAMPLE_W];
      r_pend <= (r_pend & ~w_take) | sample_valid;
      overrun <= overrun_clear ? '0 : overrun | (sample_valid & r_pend & ~w_take);
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_ptr <= CH_W'(NUM_CH - 1);
      r_ch <= '0;
      r_cnt <= '0;
      conv_sample <= '0;
      db_value <= '0;
      db_channel <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        conv_sample <= r_buf[w_idx];
        r_ch <= w_idx;
        r_ptr <= w_idx;
      end
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == WAIT && conv_done) begin
        db_value <= conv_db;
        db_channel <= r_ch;
      end
      timeout_err <= !overrun_clear && (timeout_err || w_timeout);
    end

`ifdef PEAK_HOLD_EN
  logic [DB_W-1:0] r_peak [NUM_CH];

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) r_peak[k] <= PEAK_INIT;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (db_valid && db_channel == CH_W'(k))
          r_peak[k] <= (peak_clear[k] || db_value < r_peak[k]) ? db_value : r_peak[k];
        else if (peak_clear[k])
          r_peak[k] <= PEAK_INIT;
    end

  for (genvar p = 0; p < NUM_CH; p++) begin : g_peak
    assign peak_db[p*DB_W +: DB_W] = r_peak[p];
  end
`endif
endmodule
